// File: rtl/igr_wadj_csr_mc.sv
// rtl/igr_wadj_csr_mc.sv - ingress pause/drop CSR block with per-channel thresholds and drop counters
module igr_wadj_csr_mc #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             address,
    input  logic                   read,
    input  logic                   write,
    input  logic [3:0]             byteenable,
    input  logic [31:0]            writedata,
    output logic [31:0]            readdata,
    output logic                   readdatavalid,
    input  logic [NUM_CH-1:0]      drop_pulse,
    input  logic [NUM_CH-1:0]      pause_state,
    output logic [NUM_CH-1:0]      cfg_rx_pause_en,
    output logic [16*NUM_CH-1:0]   cfg_pause_thr,
    output logic [16*NUM_CH-1:0]   cfg_drop_thr
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [4:0]       NUM_CH_L  = 5'(NUM_CH);
    localparam logic [15:0]      PAUSE_RST = 16'h0800;
    localparam logic [15:0]      DROP_RST  = 16'h0FC0;

    logic [31:0]       scratch;
    logic              cfg_err;
    logic [15:0]       pause_thr [NUM_CH];
    logic [15:0]       drop_thr  [NUM_CH];
    logic [CNT_W-1:0]  drop_cnt  [NUM_CH];
    logic [NUM_CH-1:0] drop_seen;

    logic              aligned;
    logic              is_scratch;
    logic              is_status;
    logic [3:0]        ch_idx;
    logic              ch_hit;
    logic [1:0]        reg_off;
    logic [NUM_CH-1:0] ch_sel;
    logic [31:0]       lane_mask;
    logic [31:0]       cur_thr;
    logic [31:0]       cand_thr;
    logic              thr_ok;
    logic              thr_reject;
    logic [31:0]       rd_mux;

    // Channel blocks start at 0x10, one 16-byte block per channel.
    always_comb begin
        aligned    = (address[1:0] == 2'b00);
        is_scratch = aligned && (address[7:2] == 6'd0);
        is_status  = aligned && (address[7:2] == 6'd1);
        ch_idx     = address[7:4] - 4'd1;
        ch_hit     = aligned && (address[7:4] != 4'd0) && ({1'b0, ch_idx} < NUM_CH_L);
        reg_off    = address[3:2];
        lane_mask  = {{8{byteenable[3]}}, {8{byteenable[2]}},
                      {8{byteenable[1]}}, {8{byteenable[0]}}};
        ch_sel     = '0;
        cur_thr    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_sel[c] = ch_hit && (ch_idx == 4'(c));
            if (ch_sel[c])
                cur_thr = {drop_thr[c], pause_thr[c]};
        end
        // Threshold pair is validated as a whole after merging enabled lanes.
        cand_thr   = (cur_thr & ~lane_mask) | (writedata & lane_mask);
        thr_ok     = cand_thr[15:0] < cand_thr[31:16];
        thr_reject = write && ch_hit && (reg_off == 2'd1) && !thr_ok;
    end

    always_comb begin
        rd_mux = '0;
        if (is_scratch)
            rd_mux = scratch;
        if (is_status)
            rd_mux = {31'd0, cfg_err};
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel[c]) begin
                case (reg_off)
                    2'd0:    rd_mux = {31'd0, cfg_rx_pause_en[c]};
                    2'd1:    rd_mux = {drop_thr[c], pause_thr[c]};
                    2'd2:    rd_mux = 32'(drop_cnt[c]);
                    default: rd_mux = {30'd0, drop_seen[c], pause_state[c]};
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch         <= '0;
            cfg_err         <= 1'b0;
            cfg_rx_pause_en <= '0;
            drop_seen       <= '0;
            readdata        <= '0;
            readdatavalid   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                pause_thr[c] <= PAUSE_RST;
                drop_thr[c]  <= DROP_RST;
                drop_cnt[c]  <= '0;
            end
        end else begin
            readdatavalid <= read;
            readdata      <= read ? rd_mux : '0;
            if (write && is_scratch)
                scratch <= (scratch & ~lane_mask) | (writedata & lane_mask);
            if (thr_reject)
                cfg_err <= 1'b1;
            else if (write && is_status && byteenable[0] && writedata[0])
                cfg_err <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (write && ch_sel[c] && reg_off == 2'd0 && byteenable[0])
                    cfg_rx_pause_en[c] <= writedata[0];
                if (write && ch_sel[c] && reg_off == 2'd1 && thr_ok) begin
                    pause_thr[c] <= cand_thr[15:0];
                    drop_thr[c]  <= cand_thr[31:16];
                end
                // A pulse coinciding with clear-on-read is kept as the first new count.
                if (read && ch_sel[c] && reg_off == 2'd2)
                    drop_cnt[c] <= drop_pulse[c] ? CNT_W'(1) : '0;
                else if (drop_pulse[c] && drop_cnt[c] != CNT_MAX)
                    drop_cnt[c] <= drop_cnt[c] + CNT_W'(1);
                if (drop_pulse[c])
                    drop_seen[c] <= 1'b1;
                else if (write && ch_sel[c] && reg_off == 2'd3 && byteenable[0] && writedata[1])
                    drop_seen[c] <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cfg_pause_thr[16*c +: 16] = pause_thr[c];
            cfg_drop_thr[16*c +: 16]  = drop_thr[c];
        end
    end

endmodule

// File: tb/tb_igr_wadj_csr_mc.sv
// tb/tb_igr_wadj_csr_mc.sv - scoreboard bench for igr_wadj_csr_mc against a register-map model
module tb_igr_wadj_csr_mc;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           address;
    logic                 read;
    logic                 write;
    logic [3:0]           byteenable;
    logic [31:0]          writedata;
    logic [31:0]          readdata;
    logic                 readdatavalid;
    logic [NUM_CH-1:0]    drop_pulse;
    logic [NUM_CH-1:0]    pause_state;
    logic [NUM_CH-1:0]    cfg_rx_pause_en;
    logic [16*NUM_CH-1:0] cfg_pause_thr;
    logic [16*NUM_CH-1:0] cfg_drop_thr;

    igr_wadj_csr_mc #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid), .drop_pulse(drop_pulse), .pause_state(pause_state),
        .cfg_rx_pause_en(cfg_rx_pause_en), .cfg_pause_thr(cfg_pause_thr),
        .cfg_drop_thr(cfg_drop_thr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct { int cyc; logic [31:0] data; } exp_t;
    exp_t q[$];

    // Reference state: plain integers and bits per register field.
    logic [31:0] m_scratch;
    bit          m_err;
    bit          m_en   [NUM_CH];
    int          m_pthr [NUM_CH];
    int          m_dthr [NUM_CH];
    int          m_cnt  [NUM_CH];
    bit          m_seen [NUM_CH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_scratch = 0;
        m_err     = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_en[c] = 0; m_pthr[c] = 'h800; m_dthr[c] = 'hFC0; m_cnt[c] = 0; m_seen[c] = 0;
        end
    endtask

    function automatic logic [31:0] m_read(input int addr);
        int ch, off;
        if (addr % 4 != 0) return 0;
        if (addr == 0) return m_scratch;
        if (addr == 4) return {31'd0, m_err};
        if (addr < 16) return 0;
        ch  = addr / 16 - 1;
        off = (addr % 16) / 4;
        if (ch >= NUM_CH) return 0;
        case (off)
            0:       return {31'd0, m_en[ch]};
            1:       return (m_dthr[ch] << 16) | m_pthr[ch];
            2:       return m_cnt[ch];
            default: return {30'd0, m_seen[ch], pause_state[ch]};
        endcase
    endfunction

    function automatic int merge_bytes(input int cur, input int nw, input logic [3:0] be);
        int r = cur;
        for (int b = 0; b < 4; b++)
            if (be[b]) r = (r & ~(255 << (8*b))) | (nw & (255 << (8*b)));
        return r;
    endfunction

    task automatic m_apply(input int addr, input bit rd, input bit wr, input logic [3:0] be,
                           input logic [31:0] wd, input logic [NUM_CH-1:0] pl);
        int ch = -1, off = 0, cand, cp, cd;
        bit cleared [NUM_CH];
        if (addr % 4 == 0 && addr >= 16 && addr / 16 - 1 < NUM_CH) begin
            ch = addr / 16 - 1; off = (addr % 16) / 4;
        end
        for (int c = 0; c < NUM_CH; c++) cleared[c] = 0;
        if (wr) begin
            if (addr == 0) m_scratch = merge_bytes(m_scratch, wd, be);
            if (addr == 4 && be[0] && wd[0]) m_err = 0;
            if (ch >= 0 && off == 0 && be[0]) m_en[ch] = wd[0];
            if (ch >= 0 && off == 1) begin
                cand = merge_bytes((m_dthr[ch] << 16) | m_pthr[ch], wd, be);
                cp = cand & 'hFFFF;
                cd = (cand >> 16) & 'hFFFF;
                if (cp < cd) begin m_pthr[ch] = cp; m_dthr[ch] = cd; end
                else m_err = 1;
            end
            if (ch >= 0 && off == 3 && be[0] && wd[1]) m_seen[ch] = 0;
        end
        if (rd && ch >= 0 && off == 2) cleared[ch] = 1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cleared[c]) m_cnt[c] = pl[c];
            else if (pl[c] && m_cnt[c] < CMAX) m_cnt[c]++;
            if (pl[c]) m_seen[c] = 1;
        end
    endtask

    task automatic check_cfg();
        logic [NUM_CH-1:0]    e_en;
        logic [16*NUM_CH-1:0] e_p, e_d;
        for (int c = 0; c < NUM_CH; c++) begin
            e_en[c] = m_en[c];
            e_p[16*c +: 16] = 16'(m_pthr[c]);
            e_d[16*c +: 16] = 16'(m_dthr[c]);
        end
        chk("cfg_rx_pause_en", 64'(cfg_rx_pause_en), 64'(e_en));
        chk("cfg_pause_thr", 64'(cfg_pause_thr), 64'(e_p));
        chk("cfg_drop_thr", 64'(cfg_drop_thr), 64'(e_d));
    endtask

    // One bus cycle: inputs sampled at the next rising edge, model advanced in lockstep.
    task automatic op(input int addr, input bit rd, input bit wr, input logic [3:0] be,
                      input logic [31:0] wd, input logic [NUM_CH-1:0] pl);
        exp_t e;
        address = 8'(addr); read = rd; write = wr; byteenable = be; writedata = wd;
        drop_pulse = pl;
        if (rd) begin
            e.cyc = cyc + 1; e.data = m_read(addr); q.push_back(e);
        end
        m_apply(addr, rd, wr, be, wd, pl);
        @(posedge clk); #1;
        read = 0; write = 0; drop_pulse = '0;
        check_cfg();
    endtask

    task automatic rd_op(input int addr);
        op(addr, 1, 0, 4'h0, 32'h0, '0);
    endtask

    task automatic wr_op(input int addr, input logic [3:0] be, input logic [31:0] wd);
        op(addr, 0, 1, be, wd, '0);
    endtask

    always @(negedge clk) begin : monitor
        bit ev;
        if (!reset) begin
            ev = (q.size() > 0) && (q[0].cyc == cyc);
            if (ev || readdatavalid) begin
                chk("readdatavalid", 64'(readdatavalid), 64'(ev));
                chk("readdata", 64'(readdata), ev ? 64'(q[0].data) : 64'h0);
                if (ev) void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL readdatavalid_missing: got none expected read response for cycle %0d", q[0].cyc);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        reset = 1; address = 0; read = 0; write = 0; byteenable = 0; writedata = 0;
        drop_pulse = '0; pause_state = '0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_readdatavalid", 64'(readdatavalid), 64'h0);
        chk("reset_readdata", 64'(readdata), 64'h0);
        check_cfg();
        reset = 0;
        @(posedge clk); #1;

        // ch1 thresholds after reset
        rd_op('h24);
        // rejected ch2 write sets cfg_err, W1C clears it
        wr_op('h34, 4'hF, 32'h0100_0200);
        rd_op('h34);
        rd_op('h04);
        wr_op('h04, 4'hF, 32'h1);
        rd_op('h04);
        // partial lane write to ch0 pause threshold
        wr_op('h14, 4'h3, 32'h0000_0400);
        rd_op('h04);
        rd_op('h14);
        // drop counting with pulse during clear-on-read
        repeat (3) op('h00, 0, 0, 4'h0, 0, 4'b0001);
        op('h18, 1, 0, 4'h0, 0, 4'b0001);
        rd_op('h18);
        rd_op('h1C);
        // ch3 saturation at 8 bits
        repeat (300) op('h00, 0, 0, 4'h0, 0, 4'b1000);
        rd_op('h48);
        rd_op('h48);
        // absent channel and unmapped space
        rd_op('h50);
        wr_op('h50, 4'hF, 32'hFFFF_FFFF);
        wr_op('h54, 4'hF, 32'h0001_FFFF);
        rd_op('h54);
        rd_op('h0C);
        // simultaneous read and write returns the old value
        op('h00, 1, 1, 4'hF, 32'hDEAD_BEEF, '0);
        op('h00, 1, 1, 4'h5, 32'h1234_5678, '0);
        rd_op('h00);
        // drop_seen set wins over W1C in the same cycle
        op('h2C, 0, 1, 4'h1, 32'h2, 4'b0010);
        rd_op('h2C);
        wr_op('h2C, 4'h1, 32'h2);
        rd_op('h2C);

        for (int i = 0; i < 2500; i++) begin
            int a;
            bit r, w;
            logic [31:0] wd;
            a = $urandom_range(0, 5) * 16 + $urandom_range(0, 3) * 4;
            if ($urandom_range(0, 19) == 0) a = $urandom_range(0, 255);
            r = $urandom_range(0, 1);
            w = $urandom_range(0, 2) == 0;
            wd = $urandom;
            if ($urandom_range(0, 1) == 0) wd = wd & 32'h0FFF_0FFF;
            pause_state = NUM_CH'($urandom);
            op(a, r, w, 4'($urandom), wd,
               NUM_CH'($urandom & $urandom));
        end

        // reset during an outstanding read suppresses its response
        address = 8'h24; read = 1;
        @(posedge clk); #1;
        reset = 1; read = 0;
        #1;
        chk("rdv_killed_by_reset", 64'(readdatavalid), 64'h0);
        chk("rd_cleared_by_reset", 64'(readdata), 64'h0);
        q.delete();
        m_reset();
        address = 8'h00; write = 1; byteenable = 4'hF; writedata = 32'hCAFE_F00D;
        drop_pulse = '1;
        @(posedge clk); #1;
        write = 0; drop_pulse = '0;
        check_cfg();
        reset = 0;
        @(posedge clk); #1;
        rd_op('h00);
        rd_op('h18);
        rd_op('h1C);
        rd_op('h24);

        repeat (3) op('h00, 0, 0, 4'h0, 0, '0);
        if (q.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/igr_wadj_csr_mc.md
IGR_WADJ_CSR_MC -- requirements
Module: igr_wadj_csr_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of ingress channels (legal 1..8).
REQ-002 SHALL have parameter CNT_W, default 32, drop-counter width (legal 8..32).
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports address input 8 (byte address), read input 1, write input 1, byteenable input 4, writedata input 32.
REQ-006 SHALL have ports readdata output 32, readdatavalid output 1.
REQ-007 SHALL have port drop_pulse  input  NUM_CH  one-cycle pulse per dropped packet, per channel.
REQ-008 SHALL have port pause_state  input  NUM_CH  live per-channel RX-pause asserted level.
REQ-009 SHALL have port cfg_rx_pause_en  output  NUM_CH  per-channel RX pause enable.
REQ-010 SHALL have port cfg_pause_thr  output  16*NUM_CH  channel c at bits [16c+15:16c].
REQ-011 SHALL have port cfg_drop_thr  output  16*NUM_CH  channel c at bits [16c+15:16c].

Function
REQ-012 SHALL decode map: 0x00 scratch (RW 32b); 0x04 global status (bit0 cfg_err, W1C; rest read 0); 0x10+0x10*c channel c block.
REQ-013 SHALL decode channel block: +0x0 control (bit0 rx_pause_en RW); +0x4 thresholds ([15:0] pause, [31:16] drop, RW); +0x8 drop_count (RO, clear-on-read); +0xC status (bit0 live pause_state, bit1 drop_seen sticky W1C).
REQ-014 SHALL apply byteenable per byte lane on all RW registers; W1C bits clear only where lane enabled and data bit is 1.
REQ-015 SHALL register readdata and assert readdatavalid exactly 1 cycle after each read cycle; readdata 0 when no read.
REQ-016 SHALL return 0 for reads of unmapped addresses and channels >= NUM_CH; writes to them ignored.
REQ-017 SHALL, on threshold write, form merged candidate (enabled lanes new, others current); commit only if candidate pause < candidate drop.
REQ-018 SHALL, on rejected threshold write, leave both thresholds unchanged and set cfg_err the next cycle.
REQ-019 SHALL increment drop_count[c] on drop_pulse[c], saturating at 2^CNT_W-1; value zero-extended to 32b on read.
REQ-020 SHALL, on read of drop_count[c], return pre-read value and clear counter; if drop_pulse[c] same cycle, counter becomes 1.
REQ-021 SHALL set drop_seen[c] on drop_pulse[c]; set has priority over simultaneous W1C.
REQ-022 SHALL set cfg_err on rejected write with priority over simultaneous W1C of cfg_err.
REQ-023 SHALL treat simultaneous read and write as both executed; read returns pre-write value.
REQ-024 SHALL drive cfg_* outputs directly from registers (no combinational path from bus).

Reset
REQ-025 SHALL, while reset high, asynchronously force: scratch 0, cfg_err 0, cfg_rx_pause_en 0, every pause threshold 0x0800, every drop threshold 0x0FC0, drop counters 0, drop_seen 0, readdata 0, readdatavalid 0.
REQ-026 SHALL ignore bus and drop_pulse while reset high; reset mid-read suppresses that readdatavalid.

Verification
REQ-027 Reset release, read 0x24 (ch1 thresholds) -> readdatavalid 1 cycle later, readdata 0x0FC0_0800.
REQ-028 Write 0x34 = 0x0100_0200 byteenable 0xF (ch2) -> rejected, ch2 thresholds stay 0x0800/0x0FC0, read 0x04 = 0x1; write 0x04 = 0x1 -> reads 0x0.
REQ-029 Write 0x14 = 0x0000_0400 byteenable 0x3 -> cfg_pause_thr[15:0]=0x0400, drop 0x0FC0 unchanged, cfg_err 0.
REQ-030 Three drop_pulse[0], then read 0x18 with fourth pulse same cycle -> returns 3; next read returns 1; 0x1C bit1 = 1.
REQ-031 CNT_W=8, 300 pulses on ch3 -> read 0x48 = 0xFF; following read = 0.
REQ-032 Read 0x50 with NUM_CH=4 -> readdata 0; write 0x50 -> no output changes.
